pe_wrapper: RTL and testbench
=============================

# pe_wrapper

Eyeriss-v1-style processing element with FIFO-buffered I/O. It performs 1-D row convolution for one PE of the spatial array. Filter, ifmap and input-psum streams enter through push-side FIFOs; finished output psums leave through a show-ahead FIFO. The block sits between the global-buffer/NoC stream logic and the neighbouring PEs of a column, where psums chain vertically.

## Interface
- DATA_WIDTH, 16: element width; weights, activations and psum lanes are signed two's-complement.
- DATA_WIDTH_IFMAP, 16: ifmap word, one activation.
- DATA_WIDTH_FILTER, 64: filter word, 4 weights.
- DATA_WIDTH_PSUM, 64: psum word, 4 lanes.
- IFMAP_FIFO_DEPTH, 8; FILTER_FIFO_DEPTH, 8; PSUM_FIFO_DEPTH, 8: FIFO entries; PSUM_FIFO_DEPTH applies to both ipsum and opsum.
- S_WIDTH 5, F_WIDTH 6, U_WIDTH 3, n_WIDTH 3, p_WIDTH 5, q_WIDTH 3: config field widths.
- IFMAP_SPAD_DEPTH, 12: activations held; bounds S·q.
- FILTER_SPAD_DEPTH, 224: weights held; bounds p·q·S.
- PSUM_SPAD_DEPTH, 24: psum lanes held; bounds p.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  high = compute engine advances; low = engine frozen, FIFO ports stay live.
- configure  in  1  one-cycle strobe; latches S,F,U,n,p,q.
- busy  out  1  high from accepted configure until the last opsum word is written.
- S, F, U, n, p, q  in  field widths  taps, outputs per row, stride, ifmap rows, filters (multiple of 4), channels.
- push_ifmap / ifmap / ifmap_fifo_full  in / in 16 / out 1.
- push_filter / filter / filter_fifo_full  in / in 64 / out 1.
- push_ipsum / ipsum / ipsum_fifo_full  in / in 64 / out 1.
- pop_opsum / opsum / opsum_fifo_empty  in / out 64 / out 1.

## Operation
- Derived value: W = (F−1)·U + S. Filter group count G = p/4. Lane k of a 64-bit word is bits [16k+15:16k] and belongs to filter 4g+k.
- Stream orders:
  - Filter: p·q·S/4 words, index (g·q + c)·S + s.
  - Ifmap: n·W·q words, per row r index x·q + c.
  - Ipsum and opsum: n·F·G words, index (r·F + f)·G + g.
- Phase LOAD_FILTER: pop all filter words into the filter spad.
- Per row r, phase FILL: pop S·q activations into the ifmap spad sliding window.
- Per output position f, for each group g, phase MAC:
  - Over all (c, s), lane k accumulates act[c][f·U+s]·w[4g+k][c][s].
  - Products are truncated to 16 bits; accumulation wraps at 16 bits.
  - Accumulators live in the psum spad.
- Phase ACC: pop one ipsum word, add it lane-wise with wrap, push the result to the opsum FIFO.
- Phase SHIFT, after all groups of f: drop the oldest U·q activations and pop U·q new ones. Skipped after f = F−1.
- After row n−1 the engine enters IDLE and busy falls.
- configure is accepted only when busy = 0; configure while busy is ignored.
- An unconfigured engine pops nothing.

## Timing
- Reset values: busy 0, every *_full 0, opsum_fifo_empty 1, opsum 0; all FIFOs and spads are cleared; the FSM is IDLE.
- States: IDLE → LOAD_FILTER → FILL → MAC → ACC → (MAC for the next g | SHIFT → MAC | FILL for the next row | IDLE).
- busy rises in the cycle after configure is sampled high.
- FIFOs:
  - A push is accepted on a rising edge when full = 0; a push while full is dropped.
  - full = (count == DEPTH).
  - Simultaneous push and pop on a full FIFO keeps the count unchanged; on an empty FIFO only the push takes effect.
- Opsum FIFO is first-word-fall-through: opsum shows the head word combinationally while empty = 0, and pop_opsum advances it on the edge. A pop while empty is ignored.
- Engine pops stall (the FSM holds) while the source FIFO is empty, the opsum FIFO is full, or enable = 0.
- MAC: one (c, s) step per cycle, all 4 lanes in parallel; S·q cycles per group, plus 1 cycle for ACC.
- Reset mid-operation aborts immediately. Everything returns to reset values and the config must be reissued.

## Structure
- Package pe_pkg holds:
  - lane count 4 and the lane slice helper;
  - FSM state enum;
  - the config struct {S, F, U, n, p, q}.
- Sub-module sync_fifo (parametrized width/depth, FWFT output) is instantiated four times.
- The engine FSM and spads live in the top module.

## Test plan
- Minimal: S=1, F=1, U=1, n=1, p=4, q=1; filter lanes {1,2,3,4}; ifmap 3; ipsum lanes {10,10,10,10} → opsum {13,16,19,22}, then busy falls.
- Sliding window: S=3, F=2, U=1, n=1, p=4, q=1; ifmap 1,2,3,4; all weights 1; ipsum 0 → opsum lanes 6, then 9.
- Stride: S=1, F=2, U=2, q=1, p=4; ifmap 5,6,7; weight 2; ipsum 0 → 10, then 14.
- Back-pressure: 9 ifmap pushes while IDLE → ifmap_fifo_full after the 8th, 9th dropped. Hold pop_opsum low → opsum FIFO fills to 8 and the engine stalls with busy high.
- Reset mid-run: assert reset during MAC → busy 0, opsum_fifo_empty 1 immediately. A reconfigured run then yields correct results.
- Full layer: S=3, F=13, U=1, n=4, p=16, q=3 (W=15) with random data → all 208 opsum words match the golden model.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared types for the row-stationary processing element.
//   LANES / LANE_W : four 16-bit lanes per filter/psum word
//   pe_state_e     : engine FSM states
//   pe_cfg_t       : latched layer configuration {S, F, U, n, p, q}
//   lane_of()      : extract lane k from a packed 4-lane word
package pe_pkg;
    localparam int LANES  = 4;
    localparam int LANE_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILTER,
        FILL,
        MAC,
        ACC,
        SHIFT
    } pe_state_e;

    typedef struct packed {
        logic [4:0] s;
        logic [5:0] f;
        logic [2:0] u;
        logic [2:0] n;
        logic [4:0] p;
        logic [2:0] q;
    } pe_cfg_t;

    function automatic logic [LANE_W-1:0] lane_of(input logic [LANES*LANE_W-1:0] w, input int k);
        return w[k*LANE_W +: LANE_W];
    endfunction
endpackage

// File: rtl/pe_wrapper_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through output.
//   push_i/data_i : write side, accepted when not full (or when a pop frees a slot)
//   pop_i         : advance head; ignored while empty
//   data_o        : head word while non-empty, zero while empty
//   full_o/empty_o: occupancy flags (full = count == DEPTH)
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/pe_wrapper.sv
// pe_wrapper: 1-D row-convolution processing element with FIFO-buffered streams.
//   clk, reset (async, active low), enable (engine advance), configure (config strobe)
//   busy                 : engine running a configured layer
//   S,F,U,n,p,q          : taps, outputs/row, stride, rows, filters, channels
//   push_*/data/*_full   : filter, ifmap, ipsum input FIFOs
//   pop_opsum/opsum/opsum_fifo_empty : FWFT output psum FIFO
module pe_wrapper
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int DATA_WIDTH_IFMAP  = 16,
    parameter int DATA_WIDTH_FILTER = 64,
    parameter int DATA_WIDTH_PSUM   = 64,
    parameter int IFMAP_FIFO_DEPTH  = 8,
    parameter int FILTER_FIFO_DEPTH = 8,
    parameter int PSUM_FIFO_DEPTH   = 8,
    parameter int S_WIDTH = 5, parameter int F_WIDTH = 6, parameter int U_WIDTH = 3,
    parameter int n_WIDTH = 3, parameter int p_WIDTH = 5, parameter int q_WIDTH = 3,
    parameter int IFMAP_SPAD_DEPTH  = 12,
    parameter int FILTER_SPAD_DEPTH = 224,
    parameter int PSUM_SPAD_DEPTH   = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         configure,
    output logic                         busy,
    input  logic [S_WIDTH-1:0]           S,
    input  logic [F_WIDTH-1:0]           F,
    input  logic [U_WIDTH-1:0]           U,
    input  logic [n_WIDTH-1:0]           n,
    input  logic [p_WIDTH-1:0]           p,
    input  logic [q_WIDTH-1:0]           q,
    input  logic                         push_ifmap,
    input  logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
    output logic                         ifmap_fifo_full,
    input  logic                         push_filter,
    input  logic [DATA_WIDTH_FILTER-1:0] filter,
    output logic                         filter_fifo_full,
    input  logic                         push_ipsum,
    input  logic [DATA_WIDTH_PSUM-1:0]   ipsum,
    output logic                         ipsum_fifo_full,
    input  logic                         pop_opsum,
    output logic [DATA_WIDTH_PSUM-1:0]   opsum,
    output logic                         opsum_fifo_empty
);
    localparam int FW_WORDS = FILTER_SPAD_DEPTH / LANES;
    localparam int PS_WORDS = PSUM_SPAD_DEPTH / LANES;
    localparam int FA_W     = $clog2(FW_WORDS);
    localparam int IA_W     = $clog2(IFMAP_SPAD_DEPTH);
    localparam int PA_W     = $clog2(PS_WORDS);
    localparam int CNT_W    = 11;

    pe_state_e state_q, state_d;
    pe_cfg_t   cfg_q;

    logic [CNT_W-1:0] cnt_q, sq, uq, nfw;
    logic [4:0]       s_q;
    logic [2:0]       c_q, r_q;
    logic [5:0]       f_q;
    logic [PA_W-1:0]  g_q;
    logic [IA_W-1:0]  iaddr_q;
    logic [FA_W-1:0]  faddr_q;

    logic [DATA_WIDTH_FILTER-1:0] fspad_q [FW_WORDS];
    logic [DATA_WIDTH-1:0]        ispad_q [IFMAP_SPAD_DEPTH];
    logic [DATA_WIDTH_PSUM-1:0]   pspad_q [PS_WORDS];

    logic                         filt_empty, if_empty, ip_empty, op_full;
    logic [DATA_WIDTH_FILTER-1:0] filt_data;
    logic [DATA_WIDTH_IFMAP-1:0]  if_data;
    logic [DATA_WIDTH_PSUM-1:0]   ip_data, mac_word, acc_word;
    logic                         pop_f, pop_i, acc_go, last_step, last_grp;

    sync_fifo #(.WIDTH(DATA_WIDTH_FILTER), .DEPTH(FILTER_FIFO_DEPTH)) u_filt_fifo (
        .clk(clk), .rst_n(reset), .push_i(push_filter), .data_i(filter), .pop_i(pop_f),
        .data_o(filt_data), .full_o(filter_fifo_full), .empty_o(filt_empty));
    sync_fifo #(.WIDTH(DATA_WIDTH_IFMAP), .DEPTH(IFMAP_FIFO_DEPTH)) u_if_fifo (
        .clk(clk), .rst_n(reset), .push_i(push_ifmap), .data_i(ifmap), .pop_i(pop_i),
        .data_o(if_data), .full_o(ifmap_fifo_full), .empty_o(if_empty));
    sync_fifo #(.WIDTH(DATA_WIDTH_PSUM), .DEPTH(PSUM_FIFO_DEPTH)) u_ip_fifo (
        .clk(clk), .rst_n(reset), .push_i(push_ipsum), .data_i(ipsum), .pop_i(acc_go),
        .data_o(ip_data), .full_o(ipsum_fifo_full), .empty_o(ip_empty));
    sync_fifo #(.WIDTH(DATA_WIDTH_PSUM), .DEPTH(PSUM_FIFO_DEPTH)) u_op_fifo (
        .clk(clk), .rst_n(reset), .push_i(acc_go), .data_i(acc_word), .pop_i(pop_opsum),
        .data_o(opsum), .full_o(op_full), .empty_o(opsum_fifo_empty));

    assign busy = (state_q != IDLE);
    assign sq   = CNT_W'(cfg_q.s) * CNT_W'(cfg_q.q);
    assign uq   = CNT_W'(cfg_q.u) * CNT_W'(cfg_q.q);
    assign nfw  = (CNT_W'(cfg_q.p) * CNT_W'(cfg_q.q) * CNT_W'(cfg_q.s)) >> 2;
    assign last_step = (c_q == cfg_q.q - 3'd1) && (s_q == cfg_q.s - 5'd1);
    // Group g is the last one when its four filters reach p.
    assign last_grp  = (5'({g_q, 2'b00}) + 5'd4 == cfg_q.p);

    // Lane math wraps at 16 bits; the first (c,s) step overwrites the stale accumulator.
    always_comb begin
        mac_word = '0;
        acc_word = '0;
        for (int k = 0; k < LANES; k++) begin
            mac_word[k*LANE_W +: LANE_W] =
                ((c_q == '0 && s_q == '0) ? LANE_W'(0) : lane_of(pspad_q[g_q], k))
                + lane_of(fspad_q[faddr_q], k) * ispad_q[iaddr_q];
            acc_word[k*LANE_W +: LANE_W] = lane_of(pspad_q[g_q], k) + lane_of(ip_data, k);
        end
    end

    always_comb begin
        state_d = state_q;
        pop_f   = 1'b0;
        pop_i   = 1'b0;
        acc_go  = 1'b0;
        case (state_q)
            IDLE: if (configure) state_d = LOAD_FILTER;
            LOAD_FILTER: if (enable && !filt_empty) begin
                pop_f = 1'b1;
                if (cnt_q == nfw - CNT_W'(1)) state_d = FILL;
            end
            FILL: if (enable && !if_empty) begin
                pop_i = 1'b1;
                if (cnt_q == sq - CNT_W'(1)) state_d = MAC;
            end
            MAC: if (enable && last_step) state_d = ACC;
            ACC: if (enable && !ip_empty && !op_full) begin
                acc_go = 1'b1;
                if (!last_grp)                     state_d = MAC;
                else if (f_q != cfg_q.f - 6'd1)    state_d = SHIFT;
                else if (r_q != cfg_q.n - 3'd1)    state_d = FILL;
                else                               state_d = IDLE;
            end
            SHIFT: if (enable && !if_empty) begin
                pop_i = 1'b1;
                if (cnt_q == uq - CNT_W'(1)) state_d = MAC;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            iaddr_q <= '0;
            faddr_q <= '0;
            for (int i = 0; i < FW_WORDS; i++)         fspad_q[i] <= '0;
            for (int i = 0; i < IFMAP_SPAD_DEPTH; i++) ispad_q[i] <= '0;
            for (int i = 0; i < PS_WORDS; i++)         pspad_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (configure) begin
                    cfg_q.s <= S; cfg_q.f <= F; cfg_q.u <= U;
                    cfg_q.n <= n; cfg_q.p <= p; cfg_q.q <= q;
                    cnt_q <= '0; r_q <= '0; f_q <= '0; g_q <= '0;
                    s_q <= '0; c_q <= '0; iaddr_q <= '0; faddr_q <= '0;
                end
                LOAD_FILTER: if (pop_f) begin
                    fspad_q[cnt_q[FA_W-1:0]] <= filt_data;
                    cnt_q <= (state_d == FILL) ? '0 : cnt_q + CNT_W'(1);
                end
                FILL, SHIFT: if (pop_i) begin
                    // Sliding window: shift one slot toward 0, new activation enters at S*q-1.
                    for (int i = 0; i < IFMAP_SPAD_DEPTH; i++) begin
                        if (i + 1 == int'(sq))
                            ispad_q[i] <= if_data;
                        else if (i + 1 < int'(sq) && i < IFMAP_SPAD_DEPTH - 1)
                            ispad_q[i] <= ispad_q[(i + 1) % IFMAP_SPAD_DEPTH];
                    end
                    if (state_d == MAC) begin
                        cnt_q   <= '0;
                        faddr_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                MAC: if (enable) begin
                    pspad_q[g_q] <= mac_word;
                    // Filter words are stored in (g, c, s) order, so one counter walks them.
                    faddr_q <= faddr_q + FA_W'(1);
                    if (last_step) begin
                        s_q <= '0; c_q <= '0; iaddr_q <= '0;
                    end else if (s_q == cfg_q.s - 5'd1) begin
                        s_q     <= '0;
                        c_q     <= c_q + 3'd1;
                        iaddr_q <= IA_W'(c_q + 3'd1);
                    end else begin
                        s_q     <= s_q + 5'd1;
                        iaddr_q <= iaddr_q + IA_W'(cfg_q.q);
                    end
                end
                ACC: if (acc_go) begin
                    cnt_q <= '0;
                    if (!last_grp) g_q <= g_q + PA_W'(1);
                    else begin
                        g_q <= '0;
                        if (f_q != cfg_q.f - 6'd1) f_q <= f_q + 6'd1;
                        else begin
                            f_q <= '0;
                            r_q <= r_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_wrapper.sv
module tb_pe_wrapper;
    logic        clk = 1'b0;
    logic        reset, enable, configure;
    logic        busy;
    logic [4:0]  S;
    logic [5:0]  F;
    logic [2:0]  U, n, q;
    logic [4:0]  p;
    logic        push_ifmap, push_filter, push_ipsum, pop_opsum;
    logic [15:0] ifmap;
    logic [63:0] filter, ipsum, opsum;
    logic        ifmap_fifo_full, filter_fifo_full, ipsum_fifo_full, opsum_fifo_empty;

    pe_wrapper dut (
        .clk(clk), .reset(reset), .enable(enable), .configure(configure), .busy(busy),
        .S(S), .F(F), .U(U), .n(n), .p(p), .q(q),
        .push_ifmap(push_ifmap), .ifmap(ifmap), .ifmap_fifo_full(ifmap_fifo_full),
        .push_filter(push_filter), .filter(filter), .filter_fifo_full(filter_fifo_full),
        .push_ipsum(push_ipsum), .ipsum(ipsum), .ipsum_fifo_full(ipsum_fifo_full),
        .pop_opsum(pop_opsum), .opsum(opsum), .opsum_fifo_empty(opsum_fifo_empty));

    always #5 clk = ~clk;

    localparam int TMO = 5000;
    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] fvec [64];
    logic [15:0] ivec [256];
    logic [63:0] pvec [256];
    logic [63:0] evec [256];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic feed_filter(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int t;
            t = 0;
            while (filter_fifo_full && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) begin chk("filter_push_timeout", 1, 0); return; end
            push_filter = 1'b1; filter = fvec[i];
            @(negedge clk);
            push_filter = 1'b0;
        end
    endtask

    task automatic feed_ifmap(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int t;
            t = 0;
            while (ifmap_fifo_full && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) begin chk("ifmap_push_timeout", 1, 0); return; end
            push_ifmap = 1'b1; ifmap = ivec[i];
            @(negedge clk);
            push_ifmap = 1'b0;
        end
    endtask

    task automatic feed_ipsum(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int t;
            t = 0;
            while (ipsum_fifo_full && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) begin chk("ipsum_push_timeout", 1, 0); return; end
            push_ipsum = 1'b1; ipsum = pvec[i];
            @(negedge clk);
            push_ipsum = 1'b0;
        end
    endtask

    task automatic drain(input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) begin
            int t;
            t = 0;
            while (opsum_fifo_empty && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) begin chk({tag, "_timeout"}, 1, 0); return; end
            chk($sformatf("%s[%0d]", tag, i), opsum, evec[i]);
            pop_opsum = 1'b1;
            @(negedge clk);
            pop_opsum = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < TMO) begin @(negedge clk); t++; end
        chk(tag, busy, 0);
    endtask

    task automatic cfg(input int s_, input int f_, input int u_, input int n_, input int p_, input int q_);
        S = 5'(s_); F = 6'(f_); U = 3'(u_); n = 3'(n_); p = 5'(p_); q = 3'(q_);
        configure = 1'b1;
        @(negedge clk);
        configure = 1'b0;
    endtask

    task automatic load_sliding();
        for (int i = 0; i < 3; i++) fvec[i] = {4{16'd1}};
        for (int i = 0; i < 4; i++) ivec[i] = 16'(i + 1);
        pvec[0] = '0; pvec[1] = '0;
        evec[0] = {4{16'd6}}; evec[1] = {4{16'd9}};
    endtask

    logic [15:0] wt  [16][3][3];
    logic [15:0] act [4][15][3];
    logic [15:0] accv;

    initial begin
        reset = 1'b0; enable = 1'b1; configure = 1'b0;
        S = '0; F = '0; U = '0; n = '0; p = '0; q = '0;
        push_ifmap = 1'b0; push_filter = 1'b0; push_ipsum = 1'b0; pop_opsum = 1'b0;
        ifmap = '0; filter = '0; ipsum = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_if_full", ifmap_fifo_full, 0);
        chk("rst_f_full", filter_fifo_full, 0);
        chk("rst_ip_full", ipsum_fifo_full, 0);
        chk("rst_op_empty", opsum_fifo_empty, 1);
        chk("rst_opsum", opsum, 0);
        reset = 1'b1;
        @(negedge clk);

        // Minimal run, first held frozen by enable = 0.
        fvec[0] = {16'd4, 16'd3, 16'd2, 16'd1};
        ivec[0] = 16'd3;
        pvec[0] = {4{16'd10}};
        evec[0] = {16'd22, 16'd19, 16'd16, 16'd13};
        feed_filter(1); feed_ifmap(1); feed_ipsum(1);
        chk("busy_pre_cfg", busy, 0);
        enable = 1'b0;
        cfg(1, 1, 1, 1, 4, 1);
        chk("busy_post_cfg", busy, 1);
        repeat (20) @(negedge clk);
        chk("frozen_op_empty", opsum_fifo_empty, 1);
        enable = 1'b1;
        drain(1, "minimal");
        wait_idle("minimal_idle");

        // Sliding window.
        load_sliding();
        feed_filter(3); feed_ifmap(4); feed_ipsum(2);
        cfg(3, 2, 1, 1, 4, 1);
        drain(2, "sliding");
        wait_idle("sliding_idle");

        // Stride 2.
        fvec[0] = {4{16'd2}};
        ivec[0] = 16'd5; ivec[1] = 16'd6; ivec[2] = 16'd7;
        pvec[0] = '0; pvec[1] = '0;
        evec[0] = {4{16'd10}}; evec[1] = {4{16'd14}};
        feed_filter(1); feed_ifmap(3); feed_ipsum(2);
        cfg(1, 2, 2, 1, 4, 1);
        drain(2, "stride");
        wait_idle("stride_idle");

        // Ifmap FIFO fills at 8 entries; the 9th push is dropped.
        for (int i = 0; i < 9; i++) begin
            push_ifmap = 1'b1; ifmap = 16'(i);
            @(negedge clk);
            push_ifmap = 1'b0;
            if (i == 6) chk("if_full_at7", ifmap_fifo_full, 0);
            if (i == 7) chk("if_full_at8", ifmap_fifo_full, 1);
        end
        chk("if_full_at9", ifmap_fifo_full, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("if_full_cleared", ifmap_fifo_full, 0);
        reset = 1'b1;
        @(negedge clk);

        // Opsum back-pressure: 12 outputs, nobody pops until the engine has stalled.
        fvec[0] = {4{16'd1}};
        for (int i = 0; i < 12; i++) begin
            ivec[i] = 16'(i + 1);
            pvec[i] = '0;
            evec[i] = {4{16'(i + 1)}};
        end
        cfg(1, 12, 1, 1, 4, 1);
        fork
            feed_filter(1);
            feed_ifmap(12);
            feed_ipsum(12);
        join
        repeat (100) @(negedge clk);
        chk("stall_busy", busy, 1);
        chk("stall_op_nonempty", opsum_fifo_empty, 0);
        drain(12, "stall");
        wait_idle("stall_idle");

        // Reset mid-MAC, then a clean rerun.
        load_sliding();
        feed_filter(3); feed_ifmap(4);
        cfg(3, 2, 1, 1, 4, 1);
        repeat (7) @(negedge clk);
        chk("midrun_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_op_empty", opsum_fifo_empty, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        feed_filter(3); feed_ifmap(4); feed_ipsum(2);
        cfg(3, 2, 1, 1, 4, 1);
        drain(2, "rerun");
        wait_idle("rerun_idle");

        // Full layer: S=3 F=13 U=1 n=4 p=16 q=3, W=15.
        for (int fi = 0; fi < 16; fi++)
            for (int c = 0; c < 3; c++)
                for (int s = 0; s < 3; s++) wt[fi][c][s] = 16'($urandom);
        for (int r = 0; r < 4; r++)
            for (int x = 0; x < 15; x++)
                for (int c = 0; c < 3; c++) act[r][x][c] = 16'($urandom);
        for (int g = 0; g < 4; g++)
            for (int c = 0; c < 3; c++)
                for (int s = 0; s < 3; s++)
                    for (int k = 0; k < 4; k++) fvec[(g * 3 + c) * 3 + s][16*k +: 16] = wt[4*g + k][c][s];
        for (int r = 0; r < 4; r++)
            for (int x = 0; x < 15; x++)
                for (int c = 0; c < 3; c++) ivec[r * 45 + x * 3 + c] = act[r][x][c];
        for (int r = 0; r < 4; r++)
            for (int f = 0; f < 13; f++)
                for (int g = 0; g < 4; g++) begin
                    int idx;
                    idx = (r * 13 + f) * 4 + g;
                    pvec[idx] = {$urandom, $urandom};
                    for (int k = 0; k < 4; k++) begin
                        accv = pvec[idx][16*k +: 16];
                        for (int c = 0; c < 3; c++)
                            for (int s = 0; s < 3; s++)
                                accv = accv + act[r][f + s][c] * wt[4*g + k][c][s];
                        evec[idx][16*k +: 16] = accv;
                    end
                end
        cfg(3, 13, 1, 4, 16, 3);
        fork
            feed_filter(36);
            feed_ifmap(180);
            feed_ipsum(208);
            drain(208, "layer");
        join
        wait_idle("layer_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
